// File: rtl/tube_display_pkg.sv
// tube_display_pkg: glyph, anode and state encodings shared by the tube display.
package tube_display_pkg;

    localparam logic [7:0] SEG_0   = 8'hC0;
    localparam logic [7:0] SEG_1   = 8'hF9;
    localparam logic [7:0] SEG_2   = 8'hA4;
    localparam logic [7:0] SEG_3   = 8'hB0;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h92;
    localparam logic [7:0] SEG_6   = 8'h82;
    localparam logic [7:0] SEG_7   = 8'hF8;
    localparam logic [7:0] SEG_8   = 8'h80;
    localparam logic [7:0] SEG_9   = 8'h90;
    localparam logic [7:0] SEG_A   = 8'h88;
    localparam logic [7:0] SEG_B   = 8'h83;
    localparam logic [7:0] SEG_C   = 8'hC6;
    localparam logic [7:0] SEG_D   = 8'hA1;
    localparam logic [7:0] SEG_E   = 8'h86;
    localparam logic [7:0] SEG_F   = 8'h8E;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    typedef enum logic {
        ST_BLANK,
        ST_LIT
    } state_t;

endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: 4-bit nibble to active-low {dp,g..a} glyph; dp held off.
module hex_to_seg
    import tube_display_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/tube_display.sv
// tube_display: 8-digit multiplexed seven-segment driver with blanking gap
// between digits and optional leading-zero blanking.
module tube_display
    import tube_display_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] wdata_i,
    input  logic        we_i,
    input  logic        lzb_i,
    output logic [7:0]  seg_o,
    output logic [7:0]  an_o,
    output logic        busy_o
);

    localparam int MAXC = DIGIT_CYCLES > BLANK_CYCLES ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;

    state_t      state, state_nx;
    logic [CW-1:0] cnt;
    logic [2:0]  idx;
    logic [31:0] disp_q;
    logic [3:0]  nib;
    logic        lead;
    logic        last;
    logic [7:0]  glyph;

    hex_to_seg u_dec (
        .nib (nib),
        .seg (glyph)
    );

    always_comb begin
        last     = state == ST_BLANK ? cnt == CW'(BLANK_CYCLES - 1) : cnt == CW'(DIGIT_CYCLES - 1);
        state_nx = last ? (state == ST_BLANK ? ST_LIT : ST_BLANK) : state;
        busy_o   = state == ST_BLANK;
        an_o     = state == ST_LIT ? 8'(~(8'd1 << idx)) : AN_OFF;
        seg_o    = state == ST_LIT && !(lzb_i && lead) ? glyph : SEG_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_BLANK;
            cnt    <= '0;
            idx    <= '0;
            disp_q <= '0;
            nib    <= '0;
            lead   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= last ? '0 : cnt + 1'b1;
            if (we_i)
                disp_q <= wdata_i;
            if (state == ST_LIT && last)
                idx <= idx + 1'b1;
            // slot contents and its leading-zero status are frozen for the whole slot
            if (state == ST_BLANK && last) begin
                nib  <= disp_q[4*idx +: 4];
                lead <= idx != 3'd0 && (disp_q >> {idx, 2'b00}) == 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_tube_display.sv
// tb_tube_display: scoreboard bench; stimulus queues expected {anode,glyph}
// per digit slot, a monitor pops one entry at each slot start.
module tb_tube_display;
    import tube_display_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic        lzb = 1'b0;
    logic [31:0] wdata = '0;
    logic [7:0]  seg, an;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  prev_an = 8'hFF;
    logic [7:0]  slot_seg = 8'hFF;

    tube_display #(.DIGIT_CYCLES(4), .BLANK_CYCLES(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wdata_i (wdata),
        .we_i    (we),
        .lzb_i   (lzb),
        .seg_o   (seg),
        .an_o    (an),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // glyphs packed with digit k at bits [8k+7:8k]
    task automatic scan(input logic [63:0] g, input int n);
        logic [7:0] a;
        for (int k = 0; k < n; k++) begin
            a = 8'd1 << k;
            exp_q.push_back({~a, g[8*k +: 8]});
        end
    endtask

    task automatic goto(input int c);
        repeat (c - cyc) @(posedge clk);
        #1;
        cyc = c;
    endtask

    always @(negedge clk) begin
        check("onehot", {15'd0, $countones(~an) <= 1}, 16'd1);
        check("busy", {15'd0, busy}, {15'd0, an == 8'hFF});
        if (an != 8'hFF && an != prev_an) begin
            if (exp_q.size() == 0)
                check("slot_unexpected", {an, seg}, 16'hFFFF);
            else
                check("slot", {an, seg}, exp_q.pop_front());
            slot_seg = seg;
        end else if (an != 8'hFF)
            check("stable", {8'd0, seg}, {8'd0, slot_seg});
        prev_an = an;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("in_reset", {an, seg}, 16'hFFFF);
        check("in_reset_busy", {15'd0, busy}, 16'd1);
        scan(64'hC0C0C0C0C0C0C0C0, 8);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc = 0;
        check("rel_c0", {an, seg}, 16'hFFFF);
        goto(1);
        check("rel_c1", {an, seg}, 16'hFFFF);
        goto(2);
        check("first_lit", {an, seg}, {8'hFE, SEG_0});
        goto(45);
        we = 1'b1;
        wdata = 32'h1234ABCD;
        scan(64'hF9A4B0998883C6A1, 8);
        goto(46);
        we = 1'b0;
        goto(93);
        lzb = 1'b1;
        we = 1'b1;
        wdata = 32'h000000F0;
        scan(64'hFFFFFFFFFFFF8EC0, 8);
        goto(94);
        we = 1'b0;
        goto(141);
        we = 1'b1;
        wdata = 32'h0;
        scan(64'hFFFFFFFFFFFFFFC0, 8);
        goto(142);
        we = 1'b0;
        goto(192);
        lzb = 1'b0;
        scan(64'hA4A4A4C0C0C0C0C0, 8);
        goto(219);
        we = 1'b1;
        wdata = 32'h11111111;
        goto(220);
        wdata = 32'h22222222;
        goto(221);
        we = 1'b0;
        scan(64'hA4A4A4A4A4A4A4A4, 6);
        goto(273);
        check("pre_rst_lit", {an, seg}, {8'hDF, SEG_2});
        rst_n = 1'b0;
        #1;
        check("mid_rst", {an, seg}, 16'hFFFF);
        check("mid_rst_busy", {15'd0, busy}, 16'd1);
        scan(64'hC0C0C0C0C0C0C0C0, 2);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++)
            @(posedge clk);
        #1;
        check("drained", 16'(exp_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
